// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - UART transmitter request/status bundle with master and slave views.
interface uart_tx_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_tx_break;
    logic                    uart_txd;
    logic                    uart_tx_busy;

    modport master (
        output uart_tx_en,
        output uart_tx_data,
        output uart_tx_break,
        input  uart_txd,
        input  uart_tx_busy
    );

    modport slave (
        input  uart_tx_en,
        input  uart_tx_data,
        input  uart_tx_break,
        output uart_txd,
        output uart_tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, stop bit(s) and line break.
// Optional even parity bit after the data when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 48000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave tx
);
    localparam int CPB         = CLK_HZ / BIT_RATE;
    localparam int CW          = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BW          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam int BRK_PERIODS = 1 + PAYLOAD_BITS + STOP_BITS;
    localparam int KW          = $clog2(BRK_PERIODS);

    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [KW-1:0] BRK_LAST  = KW'(BRK_PERIODS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [KW-1:0]           brk_q, brk_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    period_end;
`ifdef UART_TX_PARITY_EN
    logic                    par_q, par_d;
`endif

    assign period_end = (cyc_q == CPB_LAST);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        brk_d   = brk_q;
        shift_d = shift_q;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        // Every non-idle state is timed in whole bit periods by the shared cycle counter.
        if (state_q != IDLE) begin
            cyc_d = period_end ? '0 : cyc_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                brk_d = '0;
                if (tx.uart_tx_break) begin
                    state_d = BREAK;
                end else if (tx.uart_tx_en) begin
                    shift_d = tx.uart_tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx.uart_tx_data;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (period_end) state_d = DATA;
            end
            DATA: begin
                if (period_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (period_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (period_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            BREAK: begin
                if (period_end) begin
                    if (brk_q == BRK_LAST) begin
                        brk_d   = '0;
                        state_d = STOP;
                    end else begin
                        brk_d = brk_q + KW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line and busy are registered from the next state so they move with it.
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   txd_d = 1'b0;
            BREAK:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = par_q;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            brk_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            brk_q   <= brk_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx.uart_txd     = txd_q;
    assign tx.uart_tx_busy = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx at a reduced clock/bit-rate ratio (CPB=16).
module tb_uart_tx;
    localparam int CLK_HZ   = 1600;
    localparam int BIT_RATE = 100;
    localparam int CPB      = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (10 + P) * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if #(.PAYLOAD_BITS(8)) bus ();

    uart_tx #(
        .BIT_RATE    (BIT_RATE),
        .CLK_HZ      (CLK_HZ),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .tx   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one cycle after the accept edge; samples each bit mid-period and counts busy cycles.
    task automatic check_frame(input string tag, input logic [9:0] exp10, input logic exp_par,
                               input logic [7:0] poke);
        logic [10:0] got;
        logic [10:0] expf;
        int n;
        got  = '0;
        n    = 0;
        expf = (P == 1) ? {exp10[9], exp_par, exp10[8:0]} : {1'b0, exp10};
        while (bus.uart_tx_busy === 1'b1 && n < FRAME + 4 * CPB) begin
            if (n % CPB == CPB / 2 && n / CPB <= 10) got[n / CPB] = bus.uart_txd;
            if (n == 3 * CPB) bus.uart_tx_data = poke;
            step(1);
            n++;
        end
        chk({tag, " bits"}, 32'(got), 32'(expf));
        chk({tag, " busy_len"}, n, FRAME);
        chk({tag, " txd_after"}, 32'(bus.uart_txd), 32'd1);
    endtask

    initial begin
        int lo;
        int hi;
        bus.uart_tx_en    = 1'b0;
        bus.uart_tx_break = 1'b0;
        bus.uart_tx_data  = 8'h00;

        // Reset held for three cycles
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("reset txd", 32'(bus.uart_txd), 32'd1);
            chk("reset busy", 32'(bus.uart_tx_busy), 32'd0);
        end
        reset = 1'b0;
        step(2);
        chk("post-reset txd", 32'(bus.uart_txd), 32'd1);
        chk("post-reset busy", 32'(bus.uart_tx_busy), 32'd0);

        // Single byte 0xAA: serial 0,0,1,0,1,0,1,0,1,1
        bus.uart_tx_data = 8'hAA;
        bus.uart_tx_en   = 1'b1;
        step(1);
        bus.uart_tx_en = 1'b0;
        check_frame("aa", 10'b1101010100, 1'b0, 8'h00);

        // Back-to-back 0x55 then 0xAB with en held high
        bus.uart_tx_data = 8'h55;
        bus.uart_tx_en   = 1'b1;
        step(1);
        bus.uart_tx_data = 8'hAB;
        check_frame("b2b_55", 10'b1010101010, 1'b0, 8'hAB);
        step(1);
        chk("b2b gap busy", 32'(bus.uart_tx_busy), 32'd1);
        bus.uart_tx_en   = 1'b0;
        bus.uart_tx_data = 8'h00;
        check_frame("b2b_ab", 10'b1101010110, 1'b1, 8'hFF);

        // Break wins over simultaneous data request
        bus.uart_tx_data  = 8'hFF;
        bus.uart_tx_en    = 1'b1;
        bus.uart_tx_break = 1'b1;
        step(1);
        bus.uart_tx_en    = 1'b0;
        bus.uart_tx_break = 1'b0;
        lo = 0;
        hi = 0;
        while (bus.uart_tx_busy === 1'b1 && bus.uart_txd === 1'b0 && lo < 20 * CPB) begin
            step(1);
            lo++;
        end
        while (bus.uart_tx_busy === 1'b1 && bus.uart_txd === 1'b1 && hi < 20 * CPB) begin
            step(1);
            hi++;
        end
        chk("break low len", lo, 10 * CPB);
        chk("break high len", hi, CPB);
        step(CPB);
        chk("break no data busy", 32'(bus.uart_tx_busy), 32'd0);
        chk("break no data txd", 32'(bus.uart_txd), 32'd1);

        // Reset during data bit 3 of 0x0F
        bus.uart_tx_data = 8'h0F;
        bus.uart_tx_en   = 1'b1;
        step(1);
        bus.uart_tx_en = 1'b0;
        step(4 * CPB + CPB / 2);
        chk("mid bit3 busy", 32'(bus.uart_tx_busy), 32'd1);
        reset = 1'b1;
        step(1);
        chk("abort txd", 32'(bus.uart_txd), 32'd1);
        chk("abort busy", 32'(bus.uart_tx_busy), 32'd0);
        reset = 1'b0;
        step(3 * CPB);
        chk("no resume busy", 32'(bus.uart_tx_busy), 32'd0);
        chk("no resume txd", 32'(bus.uart_txd), 32'd1);
        bus.uart_tx_data = 8'h3C;
        bus.uart_tx_en   = 1'b1;
        step(1);
        bus.uart_tx_en = 1'b0;
        check_frame("after_abort_3c", 10'b1001111000, 1'b0, 8'h00);

        // 0x07 (odd ones, parity 1) and 0x03 (even ones, parity 0)
        step(2);
        bus.uart_tx_data = 8'h07;
        bus.uart_tx_en   = 1'b1;
        step(1);
        bus.uart_tx_en = 1'b0;
        check_frame("byte_07", 10'b1000001110, 1'b1, 8'h00);
        step(2);
        bus.uart_tx_data = 8'h03;
        bus.uart_tx_en   = 1'b1;
        step(1);
        bus.uart_tx_en = 1'b0;
        check_frame("byte_03", 10'b1000000110, 1'b0, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
